// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT peak detector.
// Framing states and magnitude width rule.
package fft_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_e;

    function automatic int mag_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/fft_peak_detect_if.sv
// Streaming FFT bin input and peak/error result bundle.
// master drives bins; slave is the detector.
interface fft_peak_detect_if #(
    parameter int FFT_DEPTH = 11,
    parameter int FFT_WIDTH = 20
);
    logic                          sink_sop;
    logic                          sink_eop;
    logic                          sink_valid;
    logic signed [FFT_WIDTH-1:0]   sink_Re;
    logic signed [FFT_WIDTH-1:0]   sink_Im;
    logic                          peak_valid;
    logic [FFT_DEPTH-1:0]          peak_bin;
    logic [2*FFT_WIDTH-1:0]        peak_mag;
    logic                          error;

    modport master (
        output sink_sop, sink_eop, sink_valid,
        output sink_Re, sink_Im,
        input  peak_valid, peak_bin, peak_mag, error
    );

    modport slave (
        input  sink_sop, sink_eop, sink_valid,
        input  sink_Re, sink_Im,
        output peak_valid, peak_bin, peak_mag, error
    );
endinterface

// File: rtl/fft_mag_sq.sv
// Registered Re^2+Im^2 with index and frame flags
// carried alongside; one cycle of latency.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int W = 20,
    parameter int D = 11
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  vld_i,
    input  logic                  first_i,
    input  logic                  last_i,
    input  logic [D-1:0]          idx_i,
    input  logic signed [W-1:0]   re_i,
    input  logic signed [W-1:0]   im_i,
    output logic                  vld_o,
    output logic                  first_o,
    output logic                  last_o,
    output logic [D-1:0]          idx_o,
    output logic [mag_width(W)-1:0] mag_o
);
    localparam int MW = mag_width(W);

    logic signed [MW-1:0] re_x;
    logic signed [MW-1:0] im_x;
    logic signed [MW-1:0] re_sq;
    logic signed [MW-1:0] im_sq;
    logic [MW-1:0]        mag_d;

    logic          vld_q;
    logic          first_q;
    logic          last_q;
    logic [D-1:0]  idx_q;
    logic [MW-1:0] mag_q;

    // Sign-extend first so each square is exact; the sum
    // peaks at 2**(MW-1) and fits unsigned in MW bits.
    always_comb begin
        re_x  = {{W{re_i[W-1]}}, re_i};
        im_x  = {{W{im_i[W-1]}}, im_i};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        mag_d = unsigned'(re_sq) + unsigned'(im_sq);
    end

    // Stage-1 register; reset flushes the in-flight beat.
    always_ff @(posedge clk) begin
        if (aclr) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            mag_q   <= '0;
        end else begin
            vld_q   <= vld_i;
            first_q <= first_i;
            last_q  <= last_i;
            idx_q   <= idx_i;
            mag_q   <= mag_d;
        end
    end

    assign vld_o   = vld_q;
    assign first_o = first_q;
    assign last_o  = last_q;
    assign idx_o   = idx_q;
    assign mag_o   = mag_q;
endmodule

// File: rtl/fft_peak_detect.sv
// Frame tracker plus two-stage peak search over one
// half of an FFT frame; reports the largest bin.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int FFT_DEPTH = 11,
    parameter int FFT_WIDTH = 20,
    parameter int SEARCH_LO = 1,
    parameter int SEARCH_HI = 2**(FFT_DEPTH-1) - 1
) (
    input logic              clk,
    input logic              aclr,
    fft_peak_detect_if.slave bus
);
    localparam int D  = FFT_DEPTH;
    localparam int MW = mag_width(FFT_WIDTH);
    localparam logic [D-1:0] LAST_IDX = '1;
    localparam logic [D-1:0] LO_IDX = D'(SEARCH_LO);
    localparam logic [D-1:0] HI_IDX = D'(SEARCH_HI);

    state_e        state_q, state_d;
    logic [D-1:0]  cnt_q, cnt_d;
    logic          err_d, error_q;

    logic          s_vld, s_first, s_last;
    logic [D-1:0]  s_idx;

    logic          m_vld, m_first, m_last;
    logic [D-1:0]  m_idx;
    logic [MW-1:0] m_mag;

    logic [D-1:0]  best_bin_q, new_bin;
    logic [MW-1:0] best_mag_q, new_mag;
    logic [D-1:0]  base_bin;
    logic [MW-1:0] base_mag;
    logic          in_rng;

    logic          peak_valid_q;
    logic [D-1:0]  peak_bin_q;
    logic [MW-1:0] peak_mag_q;

    // Framing: bin indexing, good/bad frame decision.
    // A sop always restarts at bin 0; inside a frame it
    // also flags the abandoned frame as an error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        s_vld   = 1'b0;
        s_first = 1'b0;
        s_last  = 1'b0;
        s_idx   = cnt_q;
        if (bus.sink_valid) begin
            if (bus.sink_sop) begin
                err_d   = (state_q == ST_FRAME);
                s_vld   = 1'b1;
                s_first = 1'b1;
                s_idx   = '0;
                if (bus.sink_eop) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_FRAME;
                    cnt_d   = D'(1);
                end
            end else if (state_q == ST_FRAME) begin
                s_vld = 1'b1;
                if (bus.sink_eop || cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (bus.sink_eop && cnt_q == LAST_IDX)
                        s_last = 1'b1;
                    else
                        err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + D'(1);
                end
            end
        end
    end

    // Framing state, bin counter and error pulse.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= err_d;
        end
    end

    fft_mag_sq #(
        .W (FFT_WIDTH),
        .D (D)
    ) u_mag (
        .clk     (clk),
        .aclr    (aclr),
        .vld_i   (s_vld),
        .first_i (s_first),
        .last_i  (s_last),
        .idx_i   (s_idx),
        .re_i    (bus.sink_Re),
        .im_i    (bus.sink_Im),
        .vld_o   (m_vld),
        .first_o (m_first),
        .last_o  (m_last),
        .idx_o   (m_idx),
        .mag_o   (m_mag)
    );

    // Running max: bin 0 reseeds to (SEARCH_LO, 0);
    // strict compare so ties keep the lower bin.
    always_comb begin
        base_bin = m_first ? LO_IDX : best_bin_q;
        base_mag = m_first ? '0 : best_mag_q;
        in_rng   = (m_idx >= LO_IDX) && (m_idx <= HI_IDX);
        new_bin  = base_bin;
        new_mag  = base_mag;
        if (in_rng && m_mag > base_mag) begin
            new_bin = m_idx;
            new_mag = m_mag;
        end
    end

    // Stage-2 tracker and held result outputs.
    always_ff @(posedge clk) begin
        if (aclr) begin
            best_bin_q   <= '0;
            best_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
        end else begin
            peak_valid_q <= 1'b0;
            if (m_vld) begin
                best_bin_q <= new_bin;
                best_mag_q <= new_mag;
                if (m_last) begin
                    peak_valid_q <= 1'b1;
                    peak_bin_q   <= new_bin;
                    peak_mag_q   <= new_mag;
                end
            end
        end
    end

    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: N=16,
// search bins 1..7, 20-bit samples.
module tb_fft_peak_detect;
    localparam int D = 4;
    localparam int W = 20;
    localparam int N = 16;

    logic clk = 1'b0;
    logic aclr;
    int   errors = 0;
    int   checks = 0;
    int   pv_cnt = 0;
    int   er_cnt = 0;
    int   pv0, er0, lsz;

    logic signed [W-1:0] fr_re [N];
    logic signed [W-1:0] fr_im [N];
    logic [D-1:0]        log_bin [$];
    logic [2*W-1:0]      log_mag [$];

    fft_peak_detect_if #(.FFT_DEPTH(D), .FFT_WIDTH(W)) bus ();

    fft_peak_detect #(
        .FFT_DEPTH (D),
        .FFT_WIDTH (W),
        .SEARCH_LO (1),
        .SEARCH_HI (7)
    ) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.peak_valid === 1'b1) begin
            pv_cnt++;
            log_bin.push_back(bus.peak_bin);
            log_mag.push_back(bus.peak_mag);
        end
        if (bus.error === 1'b1) er_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.sink_Re    = '0;
        bus.sink_Im    = '0;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    task automatic beat(input bit sop, input bit eop,
                        input int i);
        bus.sink_valid = 1'b1;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_Re    = fr_re[i];
        bus.sink_Im    = fr_im[i];
    endtask

    // Sends beats 0..n-1; returns one cycle after last.
    task automatic send(input int n, input bit eop_last,
                        input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                idle();
                repeat ($urandom_range(0, 2)) tick();
            end
            beat(i == 0, eop_last && (i == n - 1), i);
            tick();
        end
        idle();
    endtask

    // Good frame: result exactly 2 cycles after eop.
    task automatic good(input string tag,
                        input bit gaps,
                        input logic [63:0] ebin,
                        input logic [63:0] emag);
        send(N, 1'b1, gaps);
        check({tag, "_err"}, bus.error, 0);
        check({tag, "_pv1"}, bus.peak_valid, 0);
        tick();
        check({tag, "_pv2"}, bus.peak_valid, 1);
        check({tag, "_bin"}, bus.peak_bin, ebin);
        check({tag, "_mag"}, bus.peak_mag, emag);
        tick();
        check({tag, "_pv3"}, bus.peak_valid, 0);
    endtask

    initial begin
        idle();
        clear_frame();
        aclr = 1'b1;
        repeat (3) tick();
        check("rst_pv", bus.peak_valid, 0);
        check("rst_err", bus.error, 0);
        check("rst_bin", bus.peak_bin, 0);
        check("rst_mag", bus.peak_mag, 0);
        aclr = 1'b0;
        tick();

        fr_re[3] = 20'sd1000;
        good("bin3", 1'b0, 3, 1000000);
        repeat (3) tick();
        check("hold_bin", bus.peak_bin, 3);
        check("hold_mag", bus.peak_mag, 1000000);

        clear_frame();
        fr_re[0]  = 20'sd30000;
        fr_re[12] = 20'sd30000;
        fr_re[5]  = 20'sd3;
        fr_im[5]  = 20'sd4;
        good("excl", 1'b0, 5, 25);

        clear_frame();
        fr_re[2] = -20'sd524288;
        fr_im[2] = -20'sd524288;
        fr_re[6] = -20'sd524288;
        fr_im[6] = -20'sd524288;
        good("tie", 1'b0, 2, 64'd549755813888);
        good("tie_gap", 1'b1, 2, 64'd549755813888);

        clear_frame();
        fr_re[0] = 20'sd99;
        good("zero", 1'b0, 1, 0);

        // eop at index 10
        clear_frame();
        fr_re[4] = 20'sd77;
        pv0 = pv_cnt;
        send(11, 1'b1, 1'b0);
        check("eop10_err", bus.error, 1);
        tick();
        check("eop10_err2", bus.error, 0);
        tick();
        check("eop10_pv", pv_cnt - pv0, 0);
        clear_frame();
        fr_re[7] = -20'sd200;
        good("after10", 1'b0, 7, 40000);

        // sop inside frame at index 8
        er0 = er_cnt;
        clear_frame();
        fr_re[6] = 20'sd900;
        send(8, 1'b0, 1'b0);
        clear_frame();
        fr_re[4] = 20'sd500;
        fr_im[5] = 20'sd499;
        good("resop", 1'b0, 4, 250000);
        check("resop_errs", er_cnt - er0, 1);

        // sop and eop on one beat from IDLE
        er0 = er_cnt;
        pv0 = pv_cnt;
        beat(1'b1, 1'b1, 0);
        tick();
        idle();
        check("sopeop_err", bus.error, 1);
        repeat (3) tick();
        check("sopeop_pv", pv_cnt - pv0, 0);

        // reset mid-frame and on eop cycle
        er0 = er_cnt;
        pv0 = pv_cnt;
        clear_frame();
        fr_re[3] = 20'sd40;
        send(9, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 9);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        idle();
        repeat (4) tick();
        check("clr9_bin", bus.peak_bin, 0);
        check("clr9_mag", bus.peak_mag, 0);
        send(15, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 15);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        idle();
        repeat (4) tick();
        check("clr_pv", pv_cnt - pv0, 0);
        check("clr_err", er_cnt - er0, 0);
        check("clre_bin", bus.peak_bin, 0);
        check("clre_mag", bus.peak_mag, 0);
        clear_frame();
        fr_re[6] = 20'sd12;
        fr_im[1] = 20'sd11;
        good("post_clr", 1'b0, 6, 144);

        // back-to-back frames
        lsz = log_bin.size();
        er0 = er_cnt;
        clear_frame();
        fr_re[6] = 20'sd100;
        send(N, 1'b1, 1'b0);
        clear_frame();
        fr_re[2] = 20'sd7;
        send(N, 1'b1, 1'b0);
        repeat (3) tick();
        check("b2b_n", log_bin.size() - lsz, 2);
        if (log_bin.size() >= lsz + 2) begin
            check("b2b_binA", log_bin[lsz], 6);
            check("b2b_magA", log_mag[lsz], 10000);
            check("b2b_binB", log_bin[lsz+1], 2);
            check("b2b_magB", log_mag[lsz+1], 49);
        end
        check("b2b_err", er_cnt - er0, 0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameter FFT_DEPTH, default 11, log2 of frame length N (N = 2**FFT_DEPTH).
REQ-002 Parameter FFT_WIDTH, default 20, width of signed Re/Im input samples.
REQ-003 Parameter SEARCH_LO, default 1, lowest bin index searched (DC excluded).
REQ-004 Parameter SEARCH_HI, default 2**(FFT_DEPTH-1)-1, highest bin index searched (Nyquist and negative bins excluded).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 aclr  in  1  reset; synchronous, active-high.
REQ-007 sink_sop  in  1  start of frame, qualified by sink_valid.
REQ-008 sink_eop  in  1  end of frame, qualified by sink_valid.
REQ-009 sink_valid  in  1  beat is valid; low = stall.
REQ-010 sink_Re  in  FFT_WIDTH  signed real part of bin.
REQ-011 sink_Im  in  FFT_WIDTH  signed imaginary part of bin.
REQ-012 peak_valid  out  1  one-cycle pulse; peak_bin/peak_mag valid.
REQ-013 peak_bin  out  FFT_DEPTH  index of largest bin in last good frame.
REQ-014 peak_mag  out  2*FFT_WIDTH  unsigned Re^2+Im^2 of that bin.
REQ-015 error  out  1  one-cycle pulse on framing violation.

Function
REQ-016 States IDLE and FRAME; beat = cycle with sink_valid=1; non-beat cycles change nothing.
REQ-017 IDLE: beat with sop -> FRAME, bin counter=0; beats without sop ignored silently.
REQ-018 FRAME: counter increments per beat; beat's bin index = counter value at that beat.
REQ-019 Beat with eop and index N-1 -> IDLE, frame good.
REQ-020 Beat with eop and index != N-1 -> IDLE, error, no result.
REQ-021 Beat at index N-1 without eop -> IDLE, error, no result.
REQ-022 Beat with sop in FRAME -> error, prior frame abandoned, new frame starts at index 0 with this beat.
REQ-023 Beat with sop and eop together -> treated as sop per REQ-017/022, then eop per REQ-020 (error, IDLE).
REQ-024 Magnitude = Re*Re + Im*Im, full precision, 2*FFT_WIDTH bits, no overflow (-2**(W-1) on both gives 2**(2W-1)).
REQ-025 Only bins SEARCH_LO..SEARCH_HI inclusive compete; strictly-greater compare, ties keep lowest index.
REQ-026 If no searched bin has nonzero magnitude, result is bin SEARCH_LO, mag 0.
REQ-027 Pipeline: stage 1 registers magnitude+index+flags, stage 2 compares/updates; peak_valid asserts exactly 2 cycles after the good eop beat, independent of sink_valid.
REQ-028 error asserts 1 cycle after the offending beat.
REQ-029 peak_bin/peak_mag hold last result between pulses.
REQ-030 Back-to-back frames (sop on the beat after eop) are processed without loss.

Reset
REQ-031 aclr high: state IDLE, counter 0, pipeline flushed, peak_valid=0, error=0, peak_bin=0, peak_mag=0.
REQ-032 aclr has priority over all inputs; frame in progress or in pipeline is discarded with no peak_valid and no error.
REQ-033 First beat after aclr deasserts is evaluated normally.

Structure
REQ-034 Shared package fft_pkg holds the state enum and a function/constant for magnitude width (2*FFT_WIDTH).
REQ-035 One sub-module fft_mag_sq: registered Re^2+Im^2 with pass-through index/flags, 1-cycle latency.

Verification (bench uses FFT_DEPTH=4, N=16, search 1..7, FFT_WIDTH=20)
REQ-036 Bin 3 Re=1000 Im=0, others 0 -> peak_valid 2 cycles after eop, peak_bin=3, peak_mag=1000000, error=0.
REQ-037 Bin 0 and bin 12 Re=30000, bin 5 Re=3 Im=4 -> peak_bin=5, peak_mag=25.
REQ-038 Bins 2 and 6 both Re=-524288 Im=-524288 -> peak_bin=2, peak_mag=2**39; random valid gaps give identical result.
REQ-039 eop at index 10 -> error pulse 1 cycle later, no peak_valid; next good frame reports correctly.
REQ-040 sop at index 8 of a frame, then full 16-beat frame with bin 4 largest -> one error pulse, then peak_bin=4.
REQ-041 aclr pulsed at index 9, and again on eop cycle of another frame -> no peak_valid, no error, outputs 0; following frame correct.
